// File: rtl/riscv_hazard.sv
// riscv_hazard: five-stage RISC-V hazard unit. Provides operand forwarding,
// load-use and redirect stall/flush control, a data-memory wait FSM with a
// sticky timeout flag, and saturating stall/flush performance counters.
module riscv_hazard #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic [4:0]       irs1_d,
    input  logic [4:0]       irs2_d,
    input  logic [4:0]       irs1_e,
    input  logic [4:0]       irs2_e,
    input  logic [4:0]       ird_e,
    input  logic [4:0]       ird_m,
    input  logic [4:0]       ird_w,
    input  logic             ireg_write_m,
    input  logic             ireg_write_w,
    input  logic             iresult_srcb0_e,
    input  logic             ipc_src_e,
    input  logic             imem_req_m,
    input  logic             imem_ready_m,
    output logic [1:0]       oforward_a_e,
    output logic [1:0]       oforward_b_e,
    output logic             ostall_f,
    output logic             ostall_d,
    output logic             ostall_e,
    output logic             ostall_m,
    output logic             oflush_d,
    output logic             oflush_e,
    output logic             oflush_w,
    output logic             omem_busy,
    output logic             otimeout,
    output logic [CNT_W-1:0] ostall_cnt,
    output logic [CNT_W-1:0] oflush_cnt
);

    typedef enum logic {RUN, WAIT} state_t;

    // Last wait count before the timeout edge fires.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic        lw_stall, mem_stall;

    // M-stage result beats W-stage result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (ireg_write_m && ird_m != 5'd0 && ird_m == rs)
            return 2'b10;
        else if (ireg_write_w && ird_w != 5'd0 && ird_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Forwarding selects for both ALU operands.
    always_comb begin
        oforward_a_e = fwd_sel(irs1_e);
        oforward_b_e = fwd_sel(irs2_e);
    end

    // Stall/flush terms; a pending memory access suppresses D/E flushes so a
    // redirect or load-use is re-evaluated once the access completes.
    always_comb begin
        lw_stall  = iresult_srcb0_e && ird_e != 5'd0 &&
                    (ird_e == irs1_d || ird_e == irs2_d);
        mem_stall = imem_req_m && !imem_ready_m;
        ostall_f  = lw_stall | mem_stall;
        ostall_d  = lw_stall | mem_stall;
        ostall_e  = mem_stall;
        ostall_m  = mem_stall;
        oflush_w  = mem_stall;
        oflush_d  = ipc_src_e & ~mem_stall;
        oflush_e  = (lw_stall | ipc_src_e) & ~mem_stall;
    end

    // Wait FSM next state: enter WAIT while memory holds the pipe, leave as soon as it lets go.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mem_stall)  state_nxt = WAIT;
            WAIT:    if (!mem_stall) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign omem_busy = (state == WAIT);

    // FSM state register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= RUN;
        else         state <= state_nxt;
    end

    // Consecutive memory-wait counter and sticky timeout flag.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            wait_cnt <= 16'd0;
            otimeout <= 1'b0;
        end else begin
            if (!mem_stall)              wait_cnt <= 16'd0;
            else if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
            if (mem_stall && wait_cnt == TO_LAST) otimeout <= 1'b1;
        end
    end

    // Saturating performance counters for front-end stalls and redirect flushes.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ostall_cnt <= '0;
            oflush_cnt <= '0;
        end else begin
            if (ostall_f && ostall_cnt != '1) ostall_cnt <= ostall_cnt + CNT_W'(1);
            if (oflush_d && oflush_cnt != '1) oflush_cnt <= oflush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_hazard.sv
// tb_riscv_hazard: directed test-plan cases plus randomized traffic checked
// against a behavioural model of the hazard rules.
module tb_riscv_hazard;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic iclk = 1'b0;
    logic irst_n;
    logic [4:0] irs1_d, irs2_d, irs1_e, irs2_e, ird_e, ird_m, ird_w;
    logic ireg_write_m, ireg_write_w, iresult_srcb0_e, ipc_src_e;
    logic imem_req_m, imem_ready_m;
    logic [1:0] oforward_a_e, oforward_b_e;
    logic ostall_f, ostall_d, ostall_e, ostall_m;
    logic oflush_d, oflush_e, oflush_w, omem_busy, otimeout;
    logic [CNT_W-1:0] ostall_cnt, oflush_cnt;

    always #5 iclk = ~iclk;

    riscv_hazard #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .iclk(iclk), .irst_n(irst_n),
        .irs1_d(irs1_d), .irs2_d(irs2_d), .irs1_e(irs1_e), .irs2_e(irs2_e),
        .ird_e(ird_e), .ird_m(ird_m), .ird_w(ird_w),
        .ireg_write_m(ireg_write_m), .ireg_write_w(ireg_write_w),
        .iresult_srcb0_e(iresult_srcb0_e), .ipc_src_e(ipc_src_e),
        .imem_req_m(imem_req_m), .imem_ready_m(imem_ready_m),
        .oforward_a_e(oforward_a_e), .oforward_b_e(oforward_b_e),
        .ostall_f(ostall_f), .ostall_d(ostall_d), .ostall_e(ostall_e), .ostall_m(ostall_m),
        .oflush_d(oflush_d), .oflush_e(oflush_e), .oflush_w(oflush_w),
        .omem_busy(omem_busy), .otimeout(otimeout),
        .ostall_cnt(ostall_cnt), .oflush_cnt(oflush_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model state: busy mirrors "memory stalled last cycle", run_len is the
    // current consecutive stall run, counters are plain saturating ints.
    int run_len, scnt, fcnt;
    bit tmo, busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (ireg_write_m && ird_m != 0 && ird_m == rs) return 2'b10;
        if (ireg_write_w && ird_w != 0 && ird_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        return iresult_srcb0_e && ird_e != 0 && (ird_e == irs1_d || ird_e == irs2_d);
    endfunction

    function automatic bit ref_ms();
        return imem_req_m && !imem_ready_m;
    endfunction

    task automatic model_reset();
        run_len = 0; scnt = 0; fcnt = 0; tmo = 0; busy = 0;
    endtask

    task automatic check_all(input string p);
        bit lw, ms;
        lw = ref_lw();
        ms = ref_ms();
        chk({p, "_fwd_a"},   32'(oforward_a_e), 32'(ref_fwd(irs1_e)));
        chk({p, "_fwd_b"},   32'(oforward_b_e), 32'(ref_fwd(irs2_e)));
        chk({p, "_stall_f"}, 32'(ostall_f), 32'(lw | ms));
        chk({p, "_stall_d"}, 32'(ostall_d), 32'(lw | ms));
        chk({p, "_stall_e"}, 32'(ostall_e), 32'(ms));
        chk({p, "_stall_m"}, 32'(ostall_m), 32'(ms));
        chk({p, "_flush_w"}, 32'(oflush_w), 32'(ms));
        chk({p, "_flush_d"}, 32'(oflush_d), 32'(ipc_src_e & ~ms));
        chk({p, "_flush_e"}, 32'(oflush_e), 32'((lw | ipc_src_e) & ~ms));
        chk({p, "_busy"},    32'(omem_busy), 32'(busy));
        chk({p, "_timeout"}, 32'(otimeout), 32'(tmo));
        chk({p, "_scnt"},    32'(ostall_cnt), 32'(scnt));
        chk({p, "_fcnt"},    32'(oflush_cnt), 32'(fcnt));
    endtask

    // Advance one clock; model sees the inputs held across the rising edge.
    task automatic tick();
        bit lw, ms, pc;
        lw = ref_lw(); ms = ref_ms(); pc = ipc_src_e;
        @(posedge iclk);
        if (irst_n) begin
            busy = ms;
            if (ms) begin
                run_len++;
                if (run_len >= TIMEOUT) tmo = 1;
            end else run_len = 0;
            if ((lw || ms) && scnt < CMAX) scnt++;
            if (pc && !ms && fcnt < CMAX) fcnt++;
        end
        @(negedge iclk);
    endtask

    task automatic clear_in();
        irs1_d = 0; irs2_d = 0; irs1_e = 0; irs2_e = 0;
        ird_e = 0; ird_m = 0; ird_w = 0;
        ireg_write_m = 0; ireg_write_w = 0; iresult_srcb0_e = 0; ipc_src_e = 0;
        imem_req_m = 0; imem_ready_m = 0;
    endtask

    initial begin
        clear_in();
        irst_n = 1'b0;
        model_reset();
        @(negedge iclk);
        #1 check_all("rst");
        chk("rst_busy0", 32'(omem_busy), 32'd0);
        irst_n = 1'b1;

        // Forwarding priority
        ird_m = 5; ird_w = 5; ireg_write_m = 1; ireg_write_w = 1; irs1_e = 5; irs2_e = 5;
        #1 chk("fwd_m", 32'(oforward_a_e), 32'b10); check_all("fwd_m");
        ireg_write_m = 0;
        #1 chk("fwd_w", 32'(oforward_a_e), 32'b01); check_all("fwd_w");
        ird_m = 0; ird_w = 0; ireg_write_m = 1;
        #1 chk("fwd_x0", 32'(oforward_a_e), 32'b00); check_all("fwd_x0");

        // Load-use
        clear_in(); iresult_srcb0_e = 1; ird_e = 7; irs2_d = 7;
        #1 chk("lu_stall", 32'(ostall_f), 32'd1); chk("lu_flush_e", 32'(oflush_e), 32'd1);
        chk("lu_flush_d", 32'(oflush_d), 32'd0); check_all("lu");
        ird_e = 0;
        #1 chk("lu_x0", 32'(ostall_f), 32'd0); check_all("lu_x0");

        // Branch redirect
        clear_in(); ipc_src_e = 1;
        #1 chk("br_fd", 32'(oflush_d), 32'd1); chk("br_fe", 32'(oflush_e), 32'd1); check_all("br");
        tick();
        #1 chk("br_fcnt", 32'(oflush_cnt), 32'd1); check_all("br_post");

        // Memory wait of three cycles
        clear_in(); imem_req_m = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_stall_m", 32'(ostall_m), 32'd1); check_all("mw");
            tick();
        end
        imem_ready_m = 1;
        #1 chk("mw_rel", 32'(ostall_f), 32'd0); chk("mw_busy", 32'(omem_busy), 32'd1); check_all("mw_rel");
        tick();
        imem_req_m = 0;
        #1 chk("mw_idle", 32'(omem_busy), 32'd0); chk("mw_scnt", 32'(ostall_cnt), 32'd3); check_all("mw_idle");

        // Redirect held off by a memory stall
        imem_req_m = 1; imem_ready_m = 0; ipc_src_e = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("mb_fd", 32'(oflush_d), 32'd0); chk("mb_fe", 32'(oflush_e), 32'd0); check_all("mb");
            tick();
        end
        imem_ready_m = 1;
        #1 chk("mb_rel", 32'(oflush_d), 32'd1); check_all("mb_rel");
        tick();
        clear_in();

        // Timeout after TIMEOUT stall cycles, sticky past ready
        imem_req_m = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            #1 chk("to_flag", 32'(otimeout), 32'(i >= TIMEOUT)); check_all("to");
        end
        imem_ready_m = 1; tick(); imem_req_m = 0; tick();
        #1 chk("to_sticky", 32'(otimeout), 32'd1); check_all("to_sticky");

        // Reset in the middle of a wait
        imem_req_m = 1; imem_ready_m = 0; tick();
        #1 chk("rw_busy", 32'(omem_busy), 32'd1);
        irst_n = 0; model_reset();
        #1 chk("rw_busy0", 32'(omem_busy), 32'd0); chk("rw_to0", 32'(otimeout), 32'd0); check_all("rw");
        irst_n = 1;
        clear_in();
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            irs1_d = 5'($urandom_range(0, 3)); irs2_d = 5'($urandom_range(0, 3));
            irs1_e = 5'($urandom_range(0, 3)); irs2_e = 5'($urandom_range(0, 3));
            ird_e  = 5'($urandom_range(0, 3)); ird_m  = 5'($urandom_range(0, 3));
            ird_w  = 5'($urandom_range(0, 3));
            ireg_write_m = 1'($urandom); ireg_write_w = 1'($urandom);
            iresult_srcb0_e = 1'($urandom); ipc_src_e = ($urandom_range(0, 3) == 0);
            imem_req_m = ($urandom_range(0, 3) != 0);
            imem_ready_m = ($urandom_range(0, 3) == 0);
            #1 check_all("rnd");
            if ($urandom_range(0, 299) == 0) begin
                irst_n = 0; model_reset();
                #1 check_all("rnd_rst");
                irst_n = 1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_hazard.md
# riscv_hazard

Pipeline hazard unit for the five-stage RISC-V core. It consumes the pipelined control signals produced by the control unit (register-write enables in M/W, the E-stage load flag, the E-stage branch/jump redirect) and drives the signals the control unit and datapath respond to. These are the E-stage flush, per-stage stalls and flushes, and ALU operand forwarding selects. It also holds the pipeline on a data-memory handshake, with a wait FSM, a timeout flag and saturating stall/flush counters.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- TIMEOUT, 1023, consecutive memory-wait cycles before the timeout flag sets (1 ≤ TIMEOUT < 2^16)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - iclk  in  1  clock
  - irst_n  in  1  asynchronous active-low reset
- Register addresses:
  - irs1_d, irs2_d  in  5  D-stage source registers
  - irs1_e, irs2_e  in  5  E-stage source registers
  - ird_e, ird_m, ird_w  in  5  destination registers in E/M/W
- Control-unit inputs:
  - ireg_write_m, ireg_write_w  in  1  register-write enables
  - iresult_srcb0_e  in  1  E-stage instruction is a load
  - ipc_src_e  in  1  E-stage redirect (taken branch/jump)
- Data-memory handshake:
  - imem_req_m  in  1  M-stage instruction is accessing data memory
  - imem_ready_m  in  1  data memory completes the access this cycle
- Forwarding selects:
  - oforward_a_e, oforward_b_e  out  2  operand select: 00 regfile, 10 ALU result from M, 01 result from W
- Stall and flush outputs:
  - ostall_f, ostall_d, ostall_e, ostall_m  out  1  hold stage register
  - oflush_d, oflush_e, oflush_w  out  1  clear stage register to bubble
- Status outputs:
  - omem_busy  out  1  FSM in WAIT
  - otimeout  out  1  sticky memory timeout
  - ostall_cnt, oflush_cnt  out  CNT_W  saturating counters

## Operation
Forwarding (combinational), shown for operand A; operand B is identical using irs2_e:
- Select 10 when ireg_write_m, ird_m≠0 and ird_m==irs1_e.
- Otherwise select 01 when ireg_write_w, ird_w≠0 and ird_w==irs1_e.
- Otherwise select 00. M has priority over W.

Stall and flush terms (combinational):
- lw_stall = iresult_srcb0_e & ird_e≠0 & (ird_e==irs1_d | ird_e==irs2_d).
- mem_stall = imem_req_m & ~imem_ready_m.
- ostall_f = ostall_d = lw_stall | mem_stall.
- ostall_e = ostall_m = oflush_w = mem_stall.
- oflush_d = ipc_src_e & ~mem_stall.
- oflush_e = (lw_stall | ipc_src_e) & ~mem_stall.

A memory stall dominates. With mem_stall asserted no flush is issued to D or E; any pending redirect or load-use is re-evaluated once the stall releases.

FSM states: RUN and WAIT.
- RUN→WAIT on mem_stall.
- WAIT→RUN when mem_stall is low, whether because imem_ready_m rose or imem_req_m dropped.
- WAIT→WAIT otherwise.
- omem_busy = (state==WAIT).

Wait counter (16 bit, internal):
- Cleared whenever mem_stall is low.
- Incremented, saturating, on every cycle mem_stall is high.
- otimeout sets on the edge where mem_stall is high and wait_cnt==TIMEOUT-1.
- otimeout stays set until reset. It does not release the stall.

Performance counters:
- ostall_cnt increments on each cycle ostall_f is high.
- oflush_cnt increments on each cycle oflush_d is high.
- Both saturate at 2^CNT_W-1 and do not wrap.

Simultaneous events:
- lw_stall with ipc_src_e: stall F/D and flush E. oflush_d is also high. The flush wins at the D register, so the wrong-path instruction is discarded.
- imem_ready_m high in the first request cycle: no stall, and the FSM stays in RUN.

## Timing
- Forwarding, stall and flush outputs are combinational, valid in the same cycle as their inputs, with no registered latency.
- Registered state (FSM, wait_cnt, otimeout, counters) updates on the rising iclk.
- Async reset: state=RUN, wait_cnt=0, otimeout=0, ostall_cnt=0, oflush_cnt=0, hence omem_busy=0. Reset mid-WAIT returns to RUN immediately. The combinational outputs keep following their inputs during reset.
- A memory access with N cycles of ready low stalls exactly N cycles. omem_busy rises one cycle after the first stall cycle and falls one cycle after ready.
- otimeout rises one cycle after the TIMEOUT-th consecutive stall cycle.

## Test plan
- Forwarding: rd_m=rd_w=5, both write enables high, rs1_e=5 → forward_a=10. Clear write_m → 01. Set rd_m=rd_w=0 → 00.
- Load-use: load in E with rd_e=7, rs2_d=7 → stall_f=stall_d=1, flush_e=1, flush_d=0. Set rd_e=0 → no stall.
- Branch: ipc_src_e=1, no memory stall → flush_d=flush_e=1. oflush_cnt goes 0→1 after one edge.
- Memory wait: req=1, ready low for 3 cycles then high → ostall_f..m and oflush_w high exactly 3 cycles. omem_busy high for 3 cycles starting one cycle later. ostall_cnt=3.
- Memory stall with concurrent ipc_src_e=1 → flush_d=flush_e=0 for the whole wait. Flushes assert in the cycle ready rises.
- Timeout: TIMEOUT=4, ready held low for 6 cycles → otimeout rises after the 4th stall cycle. It stays 1 after ready. irst_n low clears it and returns omem_busy to 0 asynchronously.
